pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the pipelined MIPS core.
- Replaces the per-stage hand-written registers: one instance per IF/ID, ID/EX, EX/MEM or MEM/WB boundary.
- Adds a valid/ready handshake, flush, bubble injection with sideband (PC+4) pass-through, and a saturating bubble counter.
- Can optionally include a skid entry so that in_ready is a registered signal.

Parameters:
- DW, 64: payload width in bits (control plus data fields, packed by the instantiating stage).
- SW, 32: sideband width (PC+4). The sideband still advances when a bubble is inserted.
- CW, 16: bubble counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream stage holds a valid instruction.
- in_ready  out  1  stage accepts in_data this cycle.
- in_data  in  DW  upstream payload.
- in_side  in  SW  upstream sideband.
- flush  in  1  kill every held entry (branch or exception).
- bubble  in  1  insert a NOP instead of accepting the input (load-use stall).
- out_valid  out  1  output entry is valid.
- out_ready  in  1  downstream accepts the output entry.
- out_data  out  DW  payload; all zeros whenever out_valid is 0.
- out_side  out  SW  sideband.
- bubble_cnt  out  CW  number of bubbles inserted, saturating.

Behaviour:
- Reset: sampled only at a rising clk edge while reset is 0. It clears out_valid, out_data, out_side and bubble_cnt to 0, and clears the skid entry if present. Reset has priority over every other input.
- Advance condition: adv = ~out_valid | out_ready.
- Priority at each edge, below reset: flush, then bubble, then normal load, then hold.
- Flush: out_valid <= 0 and out_data <= 0, regardless of adv or bubble. out_side <= in_side. in_ready is 0 in that cycle, so no input is consumed. bubble_cnt does not change.
- Bubble (applies when adv is 1 and flush is 0): out_valid <= 0, out_data <= 0, out_side <= in_side. in_ready = 0, so the upstream entry stays put. bubble_cnt increments unless it is already all-ones, in which case it holds.
- Bubble while adv is 0: no effect and no count.
- Normal load (adv is 1, no flush, no bubble): in_ready = 1. out_valid <= in_valid. out_data <= in_valid ? in_data : 0. out_side <= in_side.
- Hold (adv is 0): all outputs keep their values and in_ready = 0.
- Latency: 1 cycle from input to output. Sustained throughput: one entry per cycle.
- in_ready is combinational from out_valid, out_ready, flush and bubble.
- An invalid output never carries nonzero payload, so downstream control decodes it as a NOP.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- When defined, a second skid entry (skid_valid, skid_data, skid_side) is added.
- in_ready becomes registered: in_ready = ~skid_valid & ~flush & ~bubble.
- An entry accepted while the main entry is valid and out_ready is 0 goes into the skid entry.
- When the main entry advances and the skid entry is full, the skid entry moves to main. A bubble in that cycle is deferred and not counted until the skid entry is empty.
- Flush clears both entries.
- Throughput is one entry per cycle. Latency is 1 cycle when the skid entry is empty, otherwise 2.
- When not defined: single entry, combinational in_ready, exactly as described in Behaviour.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams for per-boundary payload widths: IFID_DW, IDEX_DW, EXMEM_DW, MEMWB_DW;
  - PC_W = 32 and the NOP payload constant (all zeros);
  - the hazard-unit control encoding typedef (NORMAL, BUBBLE, HOLD, FLUSH).
- One sub-module, pipe_skid_entry: a single valid-tagged register holding data plus sideband, with load and clear. It is instantiated once for the main entry and once more under PIPE_STAGE_SKID_EN.

Test Plan:
1. Reset: hold reset=0 for 2 cycles with in_valid=1 and in_data=0xDEAD -> out_valid=0, out_data=0, out_side=0, bubble_cnt=0. Release reset -> the next edge loads 0xDEAD.
2. Streaming: in_valid=1 with data 1,2,3,4 on consecutive cycles and out_ready=1 -> out_data is 1,2,3,4, each one cycle later; in_ready stays 1 throughout.
3. Backpressure: out_ready=0 for 3 cycles while holding data 5 -> out_data stays 5 and in_ready=0. Restore out_ready=1 -> the next input appears on the following cycle and none are lost or duplicated.
4. Bubble: bubble=1 for one cycle with in_side=0x400004 and in_data=7 -> out_valid=0, out_data=0, out_side=0x400004, bubble_cnt=1. The next cycle then loads 7.
5. Flush with bubble: flush and bubble both 1 -> out_valid=0 and bubble_cnt unchanged. With CW=2, five bubbles -> bubble_cnt saturates at 3.
6. Skid (PIPE_STAGE_SKID_EN defined): out_ready=0 while in_valid=1 with data 8 then 9 -> 9 goes into the skid entry and in_ready=0 on the next cycle. out_ready=1 -> output order is 8 then 9.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined MIPS core inter-stage registers.
package pipe_pkg;

  localparam int unsigned PC_W     = 32;
  localparam int unsigned IFID_DW  = 64;
  localparam int unsigned IDEX_DW  = 148;
  localparam int unsigned EXMEM_DW = 107;
  localparam int unsigned MEMWB_DW = 71;

  // Widest boundary payload; narrower stages take a width-cast slice of the NOP.
  localparam int unsigned PAYLOAD_MAX_W = IDEX_DW;
  localparam logic [PAYLOAD_MAX_W-1:0] NOP_PAYLOAD = '0;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    BUBBLE = 2'd1,
    HOLD   = 2'd2,
    FLUSH  = 2'd3
  } hazard_ctrl_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// Single valid-tagged register holding payload plus sideband, with load and clear.
module pipe_skid_entry
  import pipe_pkg::*;
#(
  parameter int unsigned DW = 64,
  parameter int unsigned SW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic [SW-1:0] i_side,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [SW-1:0] o_side
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [SW-1:0] r_side;

  // An invalid entry always holds the NOP payload.
  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      r_valid <= 1'b0;
      r_data  <= DW'(NOP_PAYLOAD);
      r_side  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : DW'(NOP_PAYLOAD);
      r_side  <= i_side;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_side  = r_side;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with handshake, flush, bubble and bubble counter.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DW = 64,
  parameter int unsigned SW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [SW-1:0] in_side,
  input  logic          flush,
  input  logic          bubble,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] out_side,
  output logic [CW-1:0] bubble_cnt
);

  logic          w_adv;
  hazard_ctrl_e  w_ctrl;
  logic          w_main_load;
  logic          w_main_valid;
  logic [DW-1:0] w_main_data;
  logic [SW-1:0] w_main_side;
  logic          w_count;
  logic [CW-1:0] r_bubble_cnt;

`ifdef PIPE_STAGE_SKID_EN
  logic          w_skid_load;
  logic          w_skid_clr;
  logic          w_skid_valid;
  logic [DW-1:0] w_skid_data;
  logic [SW-1:0] w_skid_side;

  assign in_ready = ~w_skid_valid & ~flush & ~bubble;
`else
  assign in_ready = w_adv & ~flush & ~bubble;
`endif

  assign w_adv = ~out_valid | out_ready;

  always_comb begin
    if (flush)       w_ctrl = FLUSH;
    else if (!w_adv) w_ctrl = HOLD;
    else if (bubble) w_ctrl = BUBBLE;
    else             w_ctrl = NORMAL;
  end

  // Main-entry (and skid-entry) update selection.
  always_comb begin
    w_main_load  = 1'b0;
    w_main_valid = 1'b0;
    w_main_data  = in_data;
    w_main_side  = in_side;
    w_count      = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    w_skid_load  = 1'b0;
    w_skid_clr   = 1'b0;
    case (w_ctrl)
      FLUSH: begin
        w_main_load = 1'b1;
        w_skid_clr  = 1'b1;
      end
      BUBBLE, NORMAL: begin
        w_main_load = 1'b1;
        if (w_skid_valid) begin
          // Drain the skid entry first; a pending bubble waits for it.
          w_main_valid = 1'b1;
          w_main_data  = w_skid_data;
          w_main_side  = w_skid_side;
          w_skid_clr   = 1'b1;
        end else if (w_ctrl == BUBBLE) begin
          w_count = 1'b1;
        end else begin
          w_main_valid = in_valid;
        end
      end
      HOLD: w_skid_load = in_ready & in_valid;
      default: ;
    endcase
`else
    case (w_ctrl)
      FLUSH: w_main_load = 1'b1;
      BUBBLE: begin
        w_main_load = 1'b1;
        w_count     = 1'b1;
      end
      NORMAL: begin
        w_main_load  = 1'b1;
        w_main_valid = in_valid;
      end
      HOLD: ;
      default: ;
    endcase
`endif
  end

  pipe_skid_entry #(.DW(DW), .SW(SW)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (1'b0),
    .i_load  (w_main_load),
    .i_valid (w_main_valid),
    .i_data  (w_main_data),
    .i_side  (w_main_side),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_side  (out_side)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_skid_entry #(.DW(DW), .SW(SW)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_skid_clr),
    .i_load  (w_skid_load),
    .i_valid (in_valid),
    .i_data  (in_data),
    .i_side  (in_side),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_side  (w_skid_side)
  );
`endif

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bubble_cnt <= '0;
    end else if (w_count && (r_bubble_cnt != {CW{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CW'(1);
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule
